data_mem_responder: RTL

Multi-cycle data memory responder for the RISC-V core. It is the memory-side end of the load/store interface: it consumes the `MemRead`/`MemWrite` strobes issued by the main control decoder, together with the ALU address, `funct3` and store data. It performs byte, half and word accesses on a byte-addressed array, and holds the pipeline with `Stall` until the access completes. It sits between the EX/MEM stage and the write-back mux that is fed when `MemtoReg` = 1.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the EX/MEM stage and the data memory responder.
// Carries the request strobes, address, size code and store data one way,
// and the load result, completion pulse, stall and error flag back.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [31:0]           WrData;
  logic [31:0]           RdData;
  logic                  Valid;
  logic                  Stall;
  logic                  AccessErr;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output MemRead, MemWrite, Funct3, Addr, WrData,
    input  RdData, Valid, Stall, AccessErr
  );

  // Memory side: consumes requests, produces results.
  modport slave (
    input  MemRead, MemWrite, Funct3, Addr, WrData,
    output RdData, Valid, Stall, AccessErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory for RV32I loads/stores (lb/lh/lw/lbu/lhu, sb/sh/sw), little-endian.
// Latency: request seen in IDLE at T completes (Valid, DONE) at T+1+WAIT_STATES.
// Backpressure: Stall holds the pipeline from the request cycle until DONE; one access in flight.
// Optional DMEM_ALIGN_CHECK_EN: flag misaligned/unlisted accesses via AccessErr instead of
// forcing alignment and treating unlisted Funct3 as a word access.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            wait_cnt;
  logic                  req;

  // Request captured in IDLE; later strobe/address changes are ignored.
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  // Decoded access.
  logic [1:0]            acc_size;
  logic                  acc_unsigned;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [31:0]           word_rd;
  logic [31:0]           load_val;
  logic [31:0]           rd_hold;
  logic                  do_write;

  logic [7:0]            mem [DEPTH];

  assign req = bus.MemRead | bus.MemWrite;

  // State register; synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: wait-state count only runs when WAIT_STATES is non-zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state down-counter, loaded on entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (state == IDLE && state_nxt == WAIT) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Capture the request; a simultaneous read+write is a store.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && req) begin
      req_is_store <= bus.MemWrite;
      req_funct3   <= bus.Funct3;
      req_addr     <= bus.Addr;
      req_wdata    <= bus.WrData;
    end
  end

  // Size/extension decode; anything not a byte or half access is a word.
  always_comb begin
    acc_size     = SZ_W;
    acc_unsigned = 1'b0;
    case (req_funct3)
      3'b000:  acc_size = SZ_B;
      3'b001:  acc_size = SZ_H;
      3'b100:  if (!req_is_store) begin acc_size = SZ_B; acc_unsigned = 1'b1; end
      3'b101:  if (!req_is_store) begin acc_size = SZ_H; acc_unsigned = 1'b1; end
      default: acc_size = SZ_W;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic f3_legal;
  logic misaligned;

  // Loads accept 000/001/010/100/101, stores only 000/001/010.
  always_comb begin
    f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
               (!req_is_store && (req_funct3 == 3'b100 || req_funct3 == 3'b101));
  end

  assign misaligned = ((acc_size == SZ_H) && req_addr[0]) ||
                      ((acc_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign acc_err    = !f3_legal || misaligned;
  assign eff_addr   = req_addr;
`else
  assign acc_err = 1'b0;

  // Force natural alignment by dropping the low address bits.
  always_comb begin
    eff_addr = req_addr;
    if (acc_size == SZ_H)      eff_addr[0]   = 1'b0;
    else if (acc_size == SZ_W) eff_addr[1:0] = 2'b00;
  end
`endif

  assign a0 = eff_addr;
  assign a1 = eff_addr + ADDR_WIDTH'(1);
  assign a2 = eff_addr + ADDR_WIDTH'(2);
  assign a3 = eff_addr + ADDR_WIDTH'(3);

  // Little-endian gather: byte at the access address lands in bits 7:0.
  assign word_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};

  // Load extension by size and signedness.
  always_comb begin
    load_val = word_rd;
    case (acc_size)
      SZ_B: load_val = acc_unsigned ? {24'd0, word_rd[7:0]}
                                    : {{24{word_rd[7]}}, word_rd[7:0]};
      SZ_H: load_val = acc_unsigned ? {16'd0, word_rd[15:0]}
                                    : {{16{word_rd[15]}}, word_rd[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // Stores commit only in DONE, never on an illegal access or under reset.
  assign do_write = (state == DONE) && req_is_store && !acc_err && !reset;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[a0] <= req_wdata[7:0];
      if (acc_size != SZ_B) begin
        mem[a1] <= req_wdata[15:8];
      end
      if (acc_size == SZ_W) begin
        mem[a2] <= req_wdata[23:16];
        mem[a3] <= req_wdata[31:24];
      end
    end
  end

  // Load result holds from one load's DONE until the next; stores leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold <= 32'd0;
    end else if (state == DONE && !req_is_store) begin
      rd_hold <= acc_err ? 32'd0 : load_val;
    end
  end

  // Outputs: the IDLE stall term is combinational so the requester is held immediately.
  always_comb begin
    bus.Valid     = (state == DONE) && !reset;
    bus.AccessErr = (state == DONE) && !reset && acc_err;
    bus.Stall     = ((state == IDLE) && req && !reset) || (state == WAIT);
    bus.RdData    = rd_hold;
    if (state == DONE) begin
      if (acc_err)           bus.RdData = 32'd0;
      else if (!req_is_store) bus.RdData = load_val;
    end
  end

endmodule
